nrdiv_16bit: RTL



---
 rtl/nrdiv_16bit_pkg.sv | 17 +
 rtl/nrdiv_addsub.sv | 11 +
 rtl/nrdiv_16bit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/nrdiv_16bit_pkg.sv
// Shared types and constants for the 16-bit non-restoring divider.
package nrdiv_16bit_pkg;

  localparam int DIV_W     = 16;
  localparam int DIV_STEPS = 16;

  localparam logic [DIV_W-1:0] DIV_ZERO_Q = 16'hFFFF;
  localparam logic [3:0]       LAST_STEP  = 4'(DIV_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/nrdiv_addsub.sv
// Combinational 17-bit add/subtract, modulo 2^17 (carry out of bit 16 dropped).
module nrdiv_addsub (
  input  logic [16:0] a,
  input  logic [16:0] b,
  input  logic        sub,
  output logic [16:0] sum
);

  assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/nrdiv_16bit.sv
// Sequential 16-bit unsigned non-restoring divider, one quotient bit per clock,
// with a single shared 17-bit add/subtract used by both the RUN and FIX steps.
module nrdiv_16bit
  import nrdiv_16bit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in IDLE; out_valid is high only in DONE
  // and, once raised, stays high with stable data until out_ready is seen.

  state_t             state, state_nxt;
  logic [DIV_W:0]     p;
  logic [DIV_W-1:0]   q;
  logic [DIV_W-1:0]   d;
  logic [3:0]         cnt;

  logic [DIV_W:0]     as_a;
  logic [DIV_W:0]     as_b;
  logic               as_sub;
  logic [DIV_W:0]     as_sum;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // RUN feeds the shifted partial remainder; FIX feeds P unchanged for the
  // final correction, which is always an add.
  always_comb begin
    as_a   = {p[DIV_W-1:0], q[DIV_W-1]};
    as_b   = {1'b0, d};
    as_sub = 1'b0;
    if (state == FIX) begin
      as_a = p;
    end else if (state == RUN) begin
      as_sub = ~p[DIV_W];
    end
  end

  nrdiv_addsub u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .sum (as_sum)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = (divisor != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (cnt == LAST_STEP) begin
          state_nxt = FIX;
        end
      end
      FIX:     state_nxt = DONE;
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      p           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor != '0) begin
              d   <= divisor;
              q   <= dividend;
              p   <= '0;
              cnt <= '0;
            end else begin
              quotient    <= DIV_ZERO_Q;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          p   <= as_sum;
          q   <= {q[DIV_W-2:0], ~as_sum[DIV_W]};
          cnt <= cnt + 4'd1;
        end
        FIX: begin
          if (p[DIV_W]) begin
            p <= as_sum;
          end
          quotient    <= q;
          remainder   <= p[DIV_W] ? as_sum[DIV_W-1:0] : p[DIV_W-1:0];
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
